demux_param: RTL and testbench

DEMUX_PARAM -- requirements
Module: demux_param

---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux_chan.sv | 71 +++++++
 rtl/demux_param.sv | 82 ++++++++
 tb/tb_demux_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared defaults and helpers for the parameterised demultiplexer.
//   DEF_DATA_W / DEF_N_CH / DEF_CNT_W : default word width, channel count and
//                                       drop-counter width
//   STALL / DROP                      : DROP_MODE encodings
//   cls_width()                       : width of the channel index (class)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_N_CH   = 4;
  localparam int DEF_CNT_W  = 8;

  // DROP_MODE encodings: hold the source back, or accept and discard.
  localparam int STALL = 0;
  localparam int DROP  = 1;

  // Width of the class field; never below one bit so ports stay legal.
  function automatic int cls_width(input int n_ch);
    if (n_ch > 1) begin
      return $clog2(n_ch);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/demux_chan.sv
// -----------------------------------------------------------------------------
// demux_chan
// One output channel of the demultiplexer: data register, push strobe and a
// saturating drop counter.
//   clk, reset : clock and synchronous active-high reset
//   route_en   : word routed to this channel this cycle (register it, push)
//   drop_en    : word for this channel discarded this cycle (count it)
//   data_in    : word to capture
//   data_out   : last pushed word
//   push       : one-cycle write strobe, the cycle after route_en
//   drop_cnt   : saturating count of discarded words
// -----------------------------------------------------------------------------
module demux_chan
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              route_en,
  input  logic              drop_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              push,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              push_q, push_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  // Next-state: capture routed word, strobe push, saturating drop count.
  always_comb begin
    data_d = data_q;
    push_d = 1'b0;
    cnt_d  = cnt_q;
    if (route_en) begin
      data_d = data_in;
      push_d = 1'b1;
    end else begin
      data_d = data_q;
      push_d = 1'b0;
    end
    if (drop_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      push_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      push_q <= push_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out = data_q;
  // A reset raised during the push cycle kills the strobe at once, so a
  // word accepted just before reset is never seen downstream.
  assign push     = push_q & ~reset;
  assign drop_cnt = cnt_q;

endmodule

// File: rtl/demux_param.sv
// -----------------------------------------------------------------------------
// demux_param
// Routes one word per cycle to one of N_CH channels selected by class_in.
// A full destination either stalls the source (DROP_MODE=STALL) or makes the
// word be discarded and counted (DROP_MODE=DROP).
//   clk, reset : clock and synchronous active-high reset
//   data_in    : word to route
//   valid_in   : data_in / class_in valid
//   class_in   : destination channel index (the word's class)
//   ready_out  : word accepted this cycle when valid_in is also high
//   full_in    : per-channel downstream full flags
//   data_out   : packed per-channel data, slice k = channel k
//   push       : per-channel write strobe, one cycle after acceptance
//   drop_cnt   : packed per-channel saturating drop counters
// -----------------------------------------------------------------------------
module demux_param
  import demux_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int N_CH      = DEF_N_CH,
  parameter  int CNT_W     = DEF_CNT_W,
  parameter  int DROP_MODE = STALL,
  localparam int CLS_W     = cls_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   valid_in,
  input  logic [CLS_W-1:0]       class_in,
  output logic                   ready_out,
  input  logic [N_CH-1:0]        full_in,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [N_CH-1:0]        push,
  output logic [N_CH*CNT_W-1:0]  drop_cnt
);

  logic [N_CH-1:0] sel_s;
  logic            full_sel_s;
  logic            accept_s;
  logic [N_CH-1:0] route_s;
  logic [N_CH-1:0] drop_s;

  // Class decode, ready generation and per-channel route/drop enables.
  always_comb begin
    sel_s             = '0;
    sel_s[class_in]   = 1'b1;
    full_sel_s        = full_in[class_in];
    if (reset) begin
      ready_out = 1'b0;
    end else if (DROP_MODE == DROP) begin
      ready_out = 1'b1;
    end else begin
      ready_out = ~full_sel_s;
    end
    accept_s = valid_in & ready_out;
    // full_in is only looked at here, on the accept cycle.
    if (accept_s) begin
      route_s = sel_s & ~full_in;
      drop_s  = sel_s & full_in;
    end else begin
      route_s = '0;
      drop_s  = '0;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    demux_chan #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .route_en (route_s[k]),
      .drop_en  (drop_s[k]),
      .data_in  (data_in),
      .data_out (data_out[k*DATA_W +: DATA_W]),
      .push     (push[k]),
      .drop_cnt (drop_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_param.sv
module tb_demux_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance 0: default parameters, stall mode
  logic [11:0] d0_data;
  logic        d0_valid;
  logic [1:0]  d0_cls;
  logic        d0_ready;
  logic [3:0]  d0_full;
  logic [47:0] d0_dout;
  logic [3:0]  d0_push;
  logic [31:0] d0_cnt;

  // Instance 1: default widths, drop mode
  logic [11:0] d1_data;
  logic        d1_valid;
  logic [1:0]  d1_cls;
  logic        d1_ready;
  logic [3:0]  d1_full;
  logic [47:0] d1_dout;
  logic [3:0]  d1_push;
  logic [31:0] d1_cnt;

  // Instance 2: N_CH=8, DATA_W=16
  logic [15:0]  d2_data;
  logic         d2_valid;
  logic [2:0]   d2_cls;
  logic         d2_ready;
  logic [7:0]   d2_full;
  logic [127:0] d2_dout;
  logic [7:0]   d2_push;
  logic [63:0]  d2_cnt;

  demux_param u0 (
    .clk(clk), .reset(reset), .data_in(d0_data), .valid_in(d0_valid),
    .class_in(d0_cls), .ready_out(d0_ready), .full_in(d0_full),
    .data_out(d0_dout), .push(d0_push), .drop_cnt(d0_cnt)
  );

  demux_param #(.DROP_MODE(1)) u1 (
    .clk(clk), .reset(reset), .data_in(d1_data), .valid_in(d1_valid),
    .class_in(d1_cls), .ready_out(d1_ready), .full_in(d1_full),
    .data_out(d1_dout), .push(d1_push), .drop_cnt(d1_cnt)
  );

  demux_param #(.N_CH(8), .DATA_W(16)) u2 (
    .clk(clk), .reset(reset), .data_in(d2_data), .valid_in(d2_valid),
    .class_in(d2_cls), .ready_out(d2_ready), .full_in(d2_full),
    .data_out(d2_dout), .push(d2_push), .drop_cnt(d2_cnt)
  );

  typedef struct {
    int          ch;
    logic [11:0] data;
  } item_t;

  item_t       sb_q[$];
  logic [11:0] shadow  [4];
  logic [7:0]  exp_cnt [4];
  int          errors = 0;
  int          checks = 0;
  logic [11:0] sweep_data [4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: enqueue expectations from the inputs presented, then compare.
  task automatic tick();
    item_t it;
    item_t it_new;
    logic  drop1;
    logic  route1;
    int    c1;
    if (!reset && d0_valid && !d0_full[d0_cls]) begin
      it_new.ch   = int'(d0_cls);
      it_new.data = d0_data;
      sb_q.push_back(it_new);
    end
    c1     = int'(d1_cls);
    drop1  = !reset && d1_valid && d1_full[d1_cls];
    route1 = !reset && d1_valid && !d1_full[d1_cls];
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        shadow[k]  = 12'h000;
        exp_cnt[k] = 8'h00;
      end
      sb_q.delete();
    end else if (drop1 && (exp_cnt[c1] != 8'hFF)) begin
      exp_cnt[c1] = exp_cnt[c1] + 8'd1;
    end
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      shadow[it.ch] = it.data;
      chk("push0", d0_push, 4'b0001 << it.ch);
    end else begin
      chk("push0_idle", d0_push, 4'b0000);
    end
    for (int k = 0; k < 4; k++) begin
      chk("dout0_slice", d0_dout[k*12 +: 12], shadow[k]);
      chk("cnt1_slice", d1_cnt[k*8 +: 8], exp_cnt[k]);
    end
    chk("cnt0_zero", d0_cnt, 32'h0);
    chk("push1", d1_push, route1 ? (4'b0001 << c1) : 4'b0000);
  endtask

  initial begin
    sweep_data[0] = 12'h0A1;
    sweep_data[1] = 12'h0B2;
    sweep_data[2] = 12'h0C3;
    sweep_data[3] = 12'h0D4;
    for (int k = 0; k < 4; k++) begin
      shadow[k]  = 12'h000;
      exp_cnt[k] = 8'h00;
    end
    reset = 1'b1;
    d0_data = 12'h000; d0_valid = 1'b0; d0_cls = 2'd0; d0_full = 4'h0;
    d1_data = 12'h000; d1_valid = 1'b0; d1_cls = 2'd0; d1_full = 4'h0;
    d2_data = 16'h0000; d2_valid = 1'b0; d2_cls = 3'd0; d2_full = 8'h00;
    #1;
    chk("ready_in_reset", d0_ready, 1'b0);

    // Reset for two cycles, then release
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("ready_after_reset", d0_ready, 1'b1);
    chk("dout_after_reset", d0_dout, 48'h0);
    chk("push_after_reset", d0_push, 4'h0);

    // Sweep classes 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      d0_valid = 1'b1;
      d0_cls   = 2'(i);
      d0_data  = sweep_data[i];
      tick();
    end
    d0_valid = 1'b0;
    tick();
    chk("sweep_dout", d0_dout, 48'h0D40C30B20A1);

    // Stall on channel 2 for three cycles
    d0_full  = 4'b0100;
    d0_cls   = 2'd2;
    d0_data  = 12'h5A5;
    d0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", d0_ready, 1'b0);
      tick();
    end
    d0_full = 4'b0000;
    #1;
    chk("stall_release_ready", d0_ready, 1'b1);
    tick();
    chk("stall_push", d0_push, 4'b0100);
    d0_valid = 1'b0;
    tick();
    chk("stall_dout", d0_dout[35:24], 12'h5A5);

    // full_in rising on the push cycle must not cancel the push
    d0_valid = 1'b1;
    d0_cls   = 2'd0;
    d0_data  = 12'h123;
    tick();
    d0_valid = 1'b0;
    d0_full  = 4'b0001;
    #1;
    chk("push_full_late", d0_push, 4'b0001);
    d0_full = 4'b0000;
    tick();

    // Back-to-back to the same channel
    d0_valid = 1'b1;
    d0_cls   = 2'd1;
    d0_data  = 12'h111;
    tick();
    d0_data  = 12'h222;
    tick();
    d0_valid = 1'b0;
    tick();
    chk("b2b_dout", d0_dout[23:12], 12'h222);

    // Drop mode: channel 1 held full for 300 cycles
    d1_valid = 1'b1;
    d1_cls   = 2'd1;
    d1_data  = 12'h777;
    d1_full  = 4'b0010;
    #1;
    chk("drop_ready", d1_ready, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    chk("drop_sat", d1_cnt, 32'h0000FF00);
    chk("drop_no_data", d1_dout, 48'h0);
    d1_valid = 1'b0;
    d1_full  = 4'b0000;

    // Reset on the cycle after an accept
    d0_valid = 1'b1;
    d0_cls   = 2'd3;
    d0_data  = 12'hFFF;
    tick();
    d0_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_suppress_push", d0_push, 4'b0000);
    tick();
    chk("rst_dout3", d0_dout[47:36], 12'h000);
    chk("rst_cnt1", d1_cnt, 32'h0);
    reset = 1'b0;
    tick();

    // Eight channels, sixteen-bit words
    d2_valid = 1'b1;
    d2_cls   = 3'd7;
    d2_data  = 16'hBEEF;
    tick();
    d2_valid = 1'b0;
    chk("n8_push", d2_push, 8'h80);
    chk("n8_slice7", d2_dout[127:112], 16'hBEEF);
    chk("n8_others", d2_dout[111:0], 112'h0);
    tick();
    chk("n8_push_idle", d2_push, 8'h00);
    chk("n8_ready", d2_ready, 1'b1);
    chk("n8_cnt", d2_cnt, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
